// File: rtl/mux_scan_nto1.sv
// Purpose: registered N-channel x W-bit mux with a manual select path and an auto-scan sequencer.
// Latency: manual 1 cycle sel_in->out_data; scan DWELL+1 cycles start->first sample, DWELL+1 per channel.
// Backpressure: out_data/out_sel/out_valid hold while out_valid && !out_ready; the scan waits in EMIT.
//
// Ports:
//   clk, rst_n            single clock, async active-low reset
//   in_data[CH*WIDTH]     channel i at [i*WIDTH +: WIDTH]
//   ch_en[CH]             scan mask, bit i includes channel i
//   mode, sel_in, start   0=manual (sel_in) / 1=scan (start pulse); taken only in IDLE
//   out_data/out_sel/out_valid/out_ready   registered sample + valid/ready handshake
//   busy, scan_done       not-IDLE flag, one-cycle end-of-scan pulse
module mux_scan_nto1 #(
    parameter int WIDTH = 8,
    parameter int CH    = 8,
    parameter int SEL_W = $clog2(CH),
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [CH-1:0]       ch_en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel_in,
    input  logic                start,
    output logic [WIDTH-1:0]    out_data,
    output logic [SEL_W-1:0]    out_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                scan_done
);

    // A one-cycle dwell still needs a 1-bit counter that only ever holds 0.
    localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DWELL - 1);
    // One extra bit so CH itself is representable when CH is a power of two.
    localparam logic [SEL_W:0]    CH_LIM   = (SEL_W + 1)'(CH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SEL_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              out_free;
    logic              accept;
    logic              sel_ok;
    logic              cnt_zero;
    logic [SEL_W-1:0]  first_ch;
    logic              first_vld;
    logic [SEL_W-1:0]  next_ch;
    logic              next_vld;
    logic [SEL_W-1:0]  mux_idx;
    logic [WIDTH-1:0]  mux_dat;

    assign out_free = !out_valid || out_ready;
    assign accept   = out_valid && out_ready;
    assign sel_ok   = ({1'b0, sel_in} < CH_LIM);
    assign cnt_zero = (cnt_q == '0);

    // Lowest enabled channel, and lowest enabled channel strictly above the
    // pointer. Scanning downward lets the last hit win, i.e. the lowest index.
    // ch_en is read live so a mask change only affects channels not yet visited.
    always_comb begin
        first_ch  = '0;
        first_vld = 1'b0;
        next_ch   = '0;
        next_vld  = 1'b0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                first_ch  = SEL_W'(i);
                first_vld = 1'b1;
            end
            if (ch_en[i] && (SEL_W'(i) > ptr_q)) begin
                next_ch  = SEL_W'(i);
                next_vld = 1'b1;
            end
        end
    end

    // Single shared data mux: manual select in IDLE, scan pointer otherwise.
    // Out-of-range indices match no channel and yield zero (never loaded).
    assign mux_idx = (state_q == S_IDLE) ? sel_in : ptr_q;

    always_comb begin
        mux_dat = '0;
        for (int i = 0; i < CH; i++) begin
            if (mux_idx == SEL_W'(i)) begin
                mux_dat = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mode && start) state_d = first_vld ? S_DWELL : S_DONE;
            S_DWELL: if (cnt_zero) state_d = S_EMIT;
            S_EMIT:  if (accept) state_d = next_vld ? S_DWELL : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        scan_done = (state_q == S_DONE);
    end

    // Pointer, dwell counter and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mode) begin
                        if (start) begin
                            // A leftover manual sample is dropped here if not taken.
                            out_valid <= 1'b0;
                            ptr_q     <= first_ch;
                            cnt_q     <= CNT_INIT;
                        end else if (accept) begin
                            out_valid <= 1'b0;
                        end
                    end else if (out_free) begin
                        if (sel_ok) begin
                            out_data  <= mux_dat;
                            out_sel   <= sel_in;
                            out_valid <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                S_DWELL: begin
                    // Sample on the last settle edge; out_valid is already 0 here.
                    if (cnt_zero) begin
                        out_data  <= mux_dat;
                        out_sel   <= ptr_q;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        if (next_vld) begin
                            ptr_q <= next_ch;
                            cnt_q <= CNT_INIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_nto1.sv
module tb_mux_scan_nto1;

    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-channel instance
    logic [63:0] in_data;
    logic [7:0]  ch_en;
    logic        mode, start, out_ready;
    logic [2:0]  sel_in;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_valid, busy, scan_done;

    // 6-channel instance
    logic [47:0] in_data6;
    logic [5:0]  ch_en6;
    logic        mode6, start6, out_ready6;
    logic [2:0]  sel_in6;
    logic [7:0]  out_data6;
    logic [2:0]  out_sel6;
    logic        out_valid6, busy6, scan_done6;

    int vectors = 0;
    int miscompares = 0;

    // Expected per-cycle schedule of a scan, indexed by cycles after start.
    bit         exp_v  [256];
    logic [2:0] exp_s  [256];
    bit         rdy_lo [256];

    mux_scan_nto1 #(.WIDTH(8), .CH(8), .DWELL(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .ch_en(ch_en), .mode(mode),
        .sel_in(sel_in), .start(start), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .scan_done(scan_done)
    );

    mux_scan_nto1 #(.WIDTH(8), .CH(6), .DWELL(DW)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data6), .ch_en(ch_en6), .mode(mode6),
        .sel_in(sel_in6), .start(start6), .out_data(out_data6), .out_sel(out_sel6),
        .out_valid(out_valid6), .out_ready(out_ready6), .busy(busy6), .scan_done(scan_done6)
    );

    task automatic test_reset();
        #12;
        vectors++;
        if ({out_valid, busy, scan_done, out_sel, out_data} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset8: got %h want 0", {out_valid, busy, scan_done, out_sel, out_data});
        end
        vectors++;
        if ({out_valid6, busy6, scan_done6, out_sel6, out_data6} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset6: got %h want 0", {out_valid6, busy6, scan_done6, out_sel6, out_data6});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_manual_sweep();
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        mode = 1'b0;
        out_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel_in = 3'(s);
            @(posedge clk); #1;
            vectors++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 3'(s), 8'hA0 + 8'(s)}) begin
                miscompares++;
                $display("FAIL manual_sweep sel=%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         s, out_valid, out_sel, out_data, s, 8'hA0 + 8'(s));
            end
            repeat (9) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_manual_random();
        logic [7:0] exp_d;
        logic [2:0] exp_sel;
        mode = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            in_data = {$urandom, $urandom};
            sel_in  = 3'($urandom_range(0, 7));
            exp_sel = sel_in;
            exp_d   = in_data[exp_sel*8 +: 8];
            @(posedge clk); #1;
            vectors++;
            if ({out_valid, out_sel, out_data} !== {1'b1, exp_sel, exp_d}) begin
                miscompares++;
                $display("FAIL manual_random #%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         n, out_valid, out_sel, out_data, exp_sel, exp_d);
            end
        end
    endtask

    // Scan model: enabled channels in ascending order, each one DW settle
    // cycles plus one, a stalled sample holding for stall_len extra cycles.
    task automatic run_scan(input string name, input logic [7:0] mask,
                            input int stall_j, input int stall_len);
        int chans[$];
        int t, done, hold;
        for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
        for (int c = 0; c < 256; c++) begin
            exp_v[c] = 1'b0; exp_s[c] = '0; rdy_lo[c] = 1'b0;
        end
        t = 0;
        foreach (chans[k]) begin
            t += DW + 1;
            hold = (k == stall_j) ? stall_len : 0;
            for (int c = t; c < t + hold; c++) rdy_lo[c] = 1'b1;
            for (int c = t; c <= t + hold; c++) begin
                exp_v[c] = 1'b1;
                exp_s[c] = 3'(chans[k]);
            end
            t += hold;
        end
        done = t + 1;

        ch_en = mask;
        mode = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n <= done + 1; n++) begin
            @(negedge clk);
            if (n >= 1) begin
                vectors++;
                if (out_valid !== exp_v[n]) begin
                    miscompares++;
                    $display("FAIL %s valid@%0d: got %b want %b", name, n, out_valid, exp_v[n]);
                end
            end
            if (exp_v[n]) begin
                vectors++;
                if ({out_sel, out_data} !== {exp_s[n], in_data[exp_s[n]*8 +: 8]}) begin
                    miscompares++;
                    $display("FAIL %s sample@%0d: got s=%0d d=%h want s=%0d d=%h", name, n,
                             out_sel, out_data, exp_s[n], in_data[exp_s[n]*8 +: 8]);
                end
            end
            vectors++;
            if (scan_done !== (n == done)) begin
                miscompares++;
                $display("FAIL %s scan_done@%0d: got %b want %b", name, n, scan_done, (n == done));
            end
            vectors++;
            if (busy !== (n >= 1 && n <= done)) begin
                miscompares++;
                $display("FAIL %s busy@%0d: got %b want %b", name, n, busy, (n >= 1 && n <= done));
            end
            @(posedge clk); #1;
            start = 1'b0;
            out_ready = !rdy_lo[n+1];
        end
    endtask

    task automatic test_scan_sparse();
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        run_scan("scan_sparse", 8'b1010_1010, -1, 0);
    endtask

    task automatic test_backpressure();
        run_scan("backpressure", 8'b1010_1010, 1, 3);
    endtask

    task automatic test_empty_mask();
        run_scan("empty_mask", 8'h00, -1, 0);
    endtask

    task automatic test_scan_random();
        for (int r = 0; r < 5; r++) begin
            in_data = {$urandom, $urandom};
            run_scan("scan_random", 8'($urandom_range(0, 255)),
                     $urandom_range(0, 3), $urandom_range(1, 4));
        end
    endtask

    task automatic test_reset_restart();
        bit seen;
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        ch_en = 8'b0110_0100;
        mode = 1'b1;
        out_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reset_restart emit: got no out_valid within 20 cycles want out_valid=1");
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, busy, scan_done, out_sel, out_data} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %h want 0", {out_valid, busy, scan_done, out_sel, out_data});
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            vectors++;
            if ({scan_done, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_hold@%0d: got done/busy=%b want 00", n, {scan_done, busy});
            end
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            vectors++;
            if ({scan_done, busy, out_valid} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_release@%0d: got done/busy/valid=%b want 000", n,
                         {scan_done, busy, out_valid});
            end
        end
        @(posedge clk); #1;
        run_scan("restart", 8'b0110_0100, -1, 0);
    endtask

    task automatic test_ch6();
        logic [2:0] s;
        int cnt;
        bit done_seen;
        for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = 8'h50 + 8'(i);
        mode6 = 1'b0;
        out_ready6 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s = (k == 0) ? 3'd6 : (k == 1) ? 3'd7 : 3'd5;
            sel_in6 = s;
            @(posedge clk); #1;
            vectors++;
            if (out_valid6 !== (s < 3'd6)) begin
                miscompares++;
                $display("FAIL ch6_manual valid sel=%0d: got %b want %b", s, out_valid6, (s < 3'd6));
            end
            if (s < 3'd6) begin
                vectors++;
                if ({out_sel6, out_data6} !== {s, 8'h50 + 8'(s)}) begin
                    miscompares++;
                    $display("FAIL ch6_manual data: got s=%0d d=%h want s=%0d d=%h",
                             out_sel6, out_data6, s, 8'h50 + 8'(s));
                end
            end
        end
        mode6 = 1'b1;
        ch_en6 = 6'h3F;
        start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        cnt = 0;
        done_seen = 1'b0;
        for (int n = 0; n < 100 && !done_seen; n++) begin
            @(negedge clk);
            if (out_valid6 && out_ready6) begin
                vectors++;
                if ({out_sel6, out_data6} !== {3'(cnt), 8'h50 + 8'(cnt)}) begin
                    miscompares++;
                    $display("FAIL ch6_scan #%0d: got s=%0d d=%h want s=%0d d=%h",
                             cnt, out_sel6, out_data6, cnt, 8'h50 + 8'(cnt));
                end
                cnt++;
            end
            if (scan_done6) done_seen = 1'b1;
        end
        vectors++;
        if (!done_seen || cnt != 6) begin
            miscompares++;
            $display("FAIL ch6_scan count: got %0d samples done=%b want 6 samples done=1", cnt, done_seen);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        in_data = '0; ch_en = '0; mode = 1'b0; start = 1'b0; out_ready = 1'b1; sel_in = '0;
        in_data6 = '0; ch_en6 = '0; mode6 = 1'b0; start6 = 1'b0; out_ready6 = 1'b1; sel_in6 = '0;
        test_reset();
        test_manual_sweep();
        test_manual_random();
        test_scan_sparse();
        test_backpressure();
        test_empty_mask();
        test_scan_random();
        test_reset_restart();
        test_ch6();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
Parametrised, registered N-channel, W-bit multiplexer. It succeeds the fixed 8:1 combinational mux.
- Manual mode: a registered select path, one sample per cycle.
- Scan mode: an auto-sequencer that visits every enabled channel in ascending order, waits a programmable settle time on each, and emits the samples over a valid/ready output port.
- Sits between a bank of sensor/data sources and a single downstream consumer.

Parameters:
WIDTH, 8, bits per channel.
CH, 8, number of input channels (2..64; need not be a power of two).
SEL_W, $clog2(CH), select/pointer width (derived; do not override).
DWELL, 4, settle cycles per channel in scan mode (>=1).

Ports:
clk  input  1  single clock; all state on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
ch_en  input  CH  scan enable mask; bit i=1 includes channel i.
mode  input  1  0=manual, 1=scan; sampled only in IDLE.
sel_in  input  SEL_W  manual-mode channel select.
start  input  1  one-cycle request to begin a scan (mode=1, IDLE only).
out_data  output  WIDTH  registered selected sample.
out_sel  output  SEL_W  channel index of out_data.
out_valid  output  1  out_data/out_sel valid.
out_ready  input  1  consumer accepts when out_valid&&out_ready.
busy  output  1  high in any state other than IDLE.
scan_done  output  1  one-cycle pulse at scan end.

Behaviour:
- Reset (async assert, sync release):
  - out_data=0, out_sel=0, out_valid=0, busy=0, scan_done=0.
  - State=IDLE, pointer=0, dwell counter=0.
  - Reset mid-scan aborts the scan; no scan_done pulse.
- Output register "free" = !out_valid || out_ready. The output register never changes while out_valid=1 and out_ready=0.
- States are IDLE, DWELL, EMIT, DONE.
- IDLE, mode=0 (manual), each cycle the output register is free:
  - If sel_in<CH: load out_data=in_data[sel_in], out_sel=sel_in, out_valid=1.
  - Else: out_valid=0 and out_data holds its last value.
  - Latency is 1 cycle from sel_in to out_data.
- IDLE, mode=1, start=1, ch_en!=0:
  - pointer = lowest set bit of ch_en; counter = DWELL-1; go to DWELL.
  - Any out_valid left over from manual mode must be accepted, or is dropped at this edge. Dropping is defined behaviour: out_valid clears.
- IDLE, mode=1, start=1, ch_en==0: go to DONE. No out_valid is produced.
- start is ignored outside IDLE. mode changes are ignored outside IDLE.
- DWELL: occupies exactly DWELL cycles, counting down.
  - On the edge where counter==0: load out_data=in_data[pointer], out_sel=pointer, out_valid=1; go to EMIT.
  - Data is sampled from in_data at that edge, after settling.
- EMIT: hold the output until handshake. On out_valid&&out_ready:
  - out_valid clears.
  - If ch_en has a set bit above pointer: pointer = next such bit, counter = DWELL-1, go to DWELL.
  - Otherwise go to DONE.
  - ch_en is re-evaluated at each advance, so a live mask change affects only channels not yet visited.
- DONE: scan_done=1 for exactly this cycle, busy=1; go to IDLE next edge.
- Scan timing: start high in cycle k.
  - First out_valid is high in cycle k+DWELL+1.
  - With out_ready held 1, successive samples are DWELL+1 cycles apart.
  - scan_done is high in the cycle after the last accept.
- busy=1 in DWELL, EMIT and DONE; busy=0 in IDLE.
- No channel is ever skipped or duplicated under backpressure.

Test Plan:
1. Manual sweep:
   - Stimulus: WIDTH=8, CH=8, in_data ch i = 8'hA0+i, out_ready=1, sel_in 0..7, one per 10 cycles.
   - Required: one cycle after each change, out_data=8'hA0+sel_in, out_sel=sel_in, out_valid=1.
2. Scan, sparse mask:
   - Stimulus: ch_en=8'b1010_1010, DWELL=4, out_ready=1, start pulse in cycle k.
   - Required: out_sel sequence 1,3,5,7 with data A1,A3,A5,A7, valid in cycles k+5, k+10, k+15, k+20. scan_done pulses in k+21; busy falls in k+22.
3. Backpressure:
   - Stimulus: during the scan of test 2, hold out_ready=0 for 3 cycles while out_valid=1.
   - Required: out_data/out_sel/out_valid stay stable; the sequence is still 1,3,5,7; each later sample is delayed by 3 cycles.
4. Empty mask:
   - Stimulus: ch_en=0, mode=1, start.
   - Required: out_valid never rises; busy=1 and scan_done=1 for exactly one cycle; back in IDLE after.
5. Reset and restart:
   - Stimulus: assert rst_n=0 asynchronously while in EMIT with out_ready=0.
   - Required: all outputs go to 0 immediately, without waiting for a clock edge; no scan_done pulse.
   - Follow-up: after release, start again; the scan begins at the lowest enabled channel.
6. Non-power-of-two channel count:
   - Stimulus: CH=6, manual mode, sel_in=6 then 7 then 5.
   - Required: out_valid=0 for 6 and 7; for 5, out_data=in ch5 and out_valid=1. A scan with ch_en=6'b111111 emits 0..5 only.
